regfile_sequencer: RTL and testbench

- Single-issue sequencer sharing the 8-entry register bank (one write port, one muxed read port, r0 hard-wired zero) with an external combinational ALU.
- Accepts one operation per valid/ready handshake and sequences it as: read rs1, read rs2, execute, write rd.
- Sits between the instruction source and the register bank / ALU pair.

---
 rtl/regfile_sequencer_if.sv | 34 +++
 rtl/regfile_sequencer.sv | 162 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Request, register-bank and ALU signals shared between the sequencer and its environment.
// The sequencer takes the slave side; the instruction source, bank and ALU take the master side.
interface regfile_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [AW-1:0]    req_rd;
    logic [AW-1:0]    req_rs1;
    logic [AW-1:0]    req_rs2;
    logic [WIDTH-1:0] req_imm;
    logic [AW-1:0]    rf_en_in;
    logic [AW-1:0]    rf_en_out;
    logic [WIDTH-1:0] rf_in;
    logic [WIDTH-1:0] rf_out;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             done;

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, rf_out, alu_result,
        output req_ready, rf_en_in, rf_en_out, rf_in, alu_a, alu_b, alu_op, busy, done
    );

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, rf_out, alu_result,
        input  req_ready, rf_en_in, rf_en_out, rf_in, alu_a, alu_b, alu_op, busy, done
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Single-issue sequencer: read rs1, read rs2, execute on an external ALU, write rd.
// All outputs are registered; their next values are derived from the next state.
module regfile_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AW     = 3,
    parameter logic [2:0]  OP_LDI = 3'b111
) (
    input  logic               CLK,
    input  logic               RESET,
    regfile_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    state_t           state, state_nxt;

    logic [2:0]       op_q, op_nxt;
    logic [AW-1:0]    rd_q, rd_nxt;
    logic [AW-1:0]    rs1_q, rs1_nxt;
    logic [AW-1:0]    rs2_q, rs2_nxt;
    logic [WIDTH-1:0] imm_q, imm_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;

    logic             req_ready_q, req_ready_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [AW-1:0]    rf_en_in_q, rf_en_in_nxt;
    logic [AW-1:0]    rf_en_out_q, rf_en_out_nxt;
    logic [WIDTH-1:0] rf_in_q, rf_in_nxt;
    logic [WIDTH-1:0] alu_a_q, alu_a_nxt;
    logic [WIDTH-1:0] alu_b_q, alu_b_nxt;
    logic [2:0]       alu_op_q, alu_op_nxt;

    // State, capture and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_en_in_q  <= '0;
            rf_en_out_q <= '0;
            rf_in_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            rd_q        <= rd_nxt;
            rs1_q       <= rs1_nxt;
            rs2_q       <= rs2_nxt;
            imm_q       <= imm_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            result_q    <= result_nxt;
            req_ready_q <= req_ready_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            rf_en_in_q  <= rf_en_in_nxt;
            rf_en_out_q <= rf_en_out_nxt;
            rf_in_q     <= rf_in_nxt;
            alu_a_q     <= alu_a_nxt;
            alu_b_q     <= alu_b_nxt;
            alu_op_q    <= alu_op_nxt;
        end
    end

    // Next-state, captures, and next output values
    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        rd_nxt     = rd_q;
        rs1_nxt    = rs1_q;
        rs2_nxt    = rs2_q;
        imm_nxt    = imm_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        result_nxt = result_q;

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    op_nxt  = bus.req_op;
                    rd_nxt  = bus.req_rd;
                    rs1_nxt = bus.req_rs1;
                    rs2_nxt = bus.req_rs2;
                    imm_nxt = bus.req_imm;
                    if (bus.req_op == OP_LDI) begin
                        result_nxt = bus.req_imm;
                        state_nxt  = WRITE;
                    end else begin
                        state_nxt  = READ_A;
                    end
                end
            end
            READ_A: begin
                a_nxt     = bus.rf_out;
                state_nxt = READ_B;
            end
            READ_B: begin
                b_nxt     = bus.rf_out;
                state_nxt = EXEC;
            end
            EXEC: begin
                result_nxt = bus.alu_result;
                state_nxt  = WRITE;
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs for the cycle after this edge, so they are valid for the whole state
        req_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state_nxt == WRITE);
        rf_en_in_nxt  = (state_nxt == WRITE) ? rd_nxt : '0;
        rf_in_nxt     = result_nxt;
        rf_en_out_nxt = '0;
        if (state_nxt == READ_A) rf_en_out_nxt = rs1_nxt;
        if (state_nxt == READ_B) rf_en_out_nxt = rs2_nxt;
        alu_a_nxt  = alu_a_q;
        alu_b_nxt  = alu_b_q;
        alu_op_nxt = alu_op_q;
        if (state_nxt == EXEC) begin
            alu_a_nxt  = a_nxt;
            alu_b_nxt  = b_nxt;
            alu_op_nxt = op_nxt;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_en_in  = rf_en_in_q;
    assign bus.rf_en_out = rf_en_out_q;
    assign bus.rf_in     = rf_in_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register bank and ALU environment, transaction-level model,
// per-cycle output compare and directed scenarios with literal expectations.
module tb_regfile_sequencer;

    localparam logic [2:0] LDI = 3'b111;
    localparam logic [2:0] ADD = 3'b000;

    logic clk;
    logic rst_n;
    logic bank_clr;
    logic chk_en;

    regfile_sequencer_if #(.WIDTH(8), .AW(3)) bus ();

    regfile_sequencer #(.WIDTH(8), .AW(3), .OP_LDI(3'b111)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // Environment: 8-entry bank with r0 wired to zero, combinational ALU
    logic [7:0] bank [8];
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
        end else if (bus.rf_en_in != 3'd0) begin
            bank[bus.rf_en_in] <= bus.rf_in;
        end
    end
    assign bus.rf_out     = (bus.rf_en_out == 3'd0) ? 8'h00 : bank[bus.rf_en_out];
    assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    // Transaction model: an accepted op occupies m_len cycles and commits at the end of the last
    logic [7:0] m_regs [8];
    logic       m_busy;
    int         m_phase;
    int         m_len;
    logic       m_ldi;
    logic [2:0] m_op, m_rd, m_rs1, m_rs2;
    logic [7:0] m_a, m_b, m_val;
    logic [7:0] m_alu_a, m_alu_b;
    logic [2:0] m_alu_op;
    int         cyc = 0;
    int         n_acc = 0;
    int         acc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (bank_clr) for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_busy = 1'b0; m_phase = 0; m_len = 0; m_ldi = 1'b0;
            m_alu_a = 8'h00; m_alu_b = 8'h00; m_alu_op = 3'd0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (m_phase == m_len) begin
                    if (m_rd != 3'd0) m_regs[m_rd] = m_val;
                    m_busy  = 1'b0;
                    m_phase = 0;
                end else begin
                    m_phase++;
                    if (!m_ldi && m_phase == 3) begin
                        m_alu_a = m_a; m_alu_b = m_b; m_alu_op = m_op;
                    end
                end
            end else if (bus.req_valid) begin
                m_op  = bus.req_op;  m_rd  = bus.req_rd;
                m_rs1 = bus.req_rs1; m_rs2 = bus.req_rs2;
                m_ldi = (bus.req_op == LDI);
                m_len = m_ldi ? 1 : 4;
                m_a   = (m_rs1 == 3'd0) ? 8'h00 : m_regs[m_rs1];
                m_b   = (m_rs2 == 3'd0) ? 8'h00 : m_regs[m_rs2];
                m_val = m_ldi ? bus.req_imm : alu_f(m_op, m_a, m_b);
                m_busy  = 1'b1;
                m_phase = 1;
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    // Per-cycle compare against the model, plus a log of writes and reads
    int         done_cnt = 0;
    logic [2:0] last_en;
    logic [7:0] last_in;
    logic [2:0] rd_log[$];

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] e_out, e_in;
            logic       e_done;
            e_out  = 3'd0;
            e_in   = 3'd0;
            e_done = 1'b0;
            if (m_busy) begin
                if (m_phase == m_len) begin
                    e_in = m_rd; e_done = 1'b1;
                end else if (m_phase == 1) begin
                    e_out = m_rs1;
                end else if (m_phase == 2) begin
                    e_out = m_rs2;
                end
            end
            check("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            check("busy",      32'(bus.busy),      32'(m_busy));
            check("done",      32'(bus.done),      32'(e_done));
            check("rf_en_out", 32'(bus.rf_en_out), 32'(e_out));
            check("rf_en_in",  32'(bus.rf_en_in),  32'(e_in));
            check("alu_a",     32'(bus.alu_a),     32'(m_alu_a));
            check("alu_b",     32'(bus.alu_b),     32'(m_alu_b));
            check("alu_op",    32'(bus.alu_op),    32'(m_alu_op));
            if (e_done) check("rf_in", 32'(bus.rf_in), 32'(m_val));
            for (int i = 0; i < 8; i++) check("bank_vs_model", 32'(bank[i]), 32'(m_regs[i]));
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_en = bus.rf_en_in;
            last_in = bus.rf_in;
        end
        if (bus.rf_en_out !== 3'd0) rd_log.push_back(bus.rf_en_out);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm);
        bus.req_op = op; bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
    endtask

    task automatic wait_accept();
        int start;
        int k;
        start = n_acc;
        k = 0;
        while (n_acc == start && k < 20) begin tick(); k++; end
        if (n_acc == start) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Issue one op and return cycles from accept edge until req_ready returns
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm, output int lat);
        set_req(op, rd, rs1, rs2, imm);
        bus.req_valid = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.req_ready !== 1'b1 && lat < 20) begin tick(); lat++; end
    endtask

    logic [2:0] hop [3];
    logic [2:0] hrd [3];
    logic [2:0] hs1 [3];
    logic [2:0] hs2 [3];

    initial begin
        int lat;
        int d0;
        int start;
        int got;
        bus.req_valid = 1'b0;
        set_req(3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        rst_n = 1'b0; bank_clr = 1'b1; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #2 bank_clr = 1'b0;
        chk_en = 1'b1;
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_en_in", 32'(bus.rf_en_in),  32'd0);
        rst_n = 1'b1;
        tick();

        // LDI r1 = 0x05
        d0 = done_cnt;
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h05, lat);
        check("ldi_latency", 32'(lat), 32'd1);
        check("ldi_wr_en",   32'(last_en), 32'd1);
        check("ldi_wr_data", 32'(last_in), 32'h05);
        check("ldi_r1",      32'(bank[1]), 32'h05);
        check("ldi_done",    32'(done_cnt - d0), 32'd1);

        // LDI r2 = 0x03, ADD r3 = r1 + r2
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h03, lat);
        rd_log.delete();
        d0 = done_cnt;
        issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, lat);
        check("add_latency", 32'(lat), 32'd4);
        check("add_reads_n", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) begin
            check("add_read0", 32'(rd_log[0]), 32'd1);
            check("add_read1", 32'(rd_log[1]), 32'd2);
        end
        check("add_alu_a", 32'(bus.alu_a), 32'h05);
        check("add_alu_b", 32'(bus.alu_b), 32'h03);
        check("add_r3",    32'(bank[3]),   32'h08);
        check("add_done",  32'(done_cnt - d0), 32'd1);

        // Self-overwrite then dependent read with r0 operand
        issue(ADD, 3'd1, 3'd1, 3'd1, 8'h00, lat);
        check("self_r1", 32'(bank[1]), 32'h0A);
        issue(ADD, 3'd4, 3'd1, 3'd0, 8'h00, lat);
        check("dep_r4",  32'(bank[4]), 32'h0A);

        // Write to r0 is suppressed but still completes
        d0 = done_cnt;
        issue(LDI, 3'd0, 3'd0, 3'd0, 8'hFF, lat);
        check("r0_wr_en", 32'(last_en), 32'd0);
        check("r0_value", 32'(bank[0]), 32'h00);
        check("r0_done",  32'(done_cnt - d0), 32'd1);

        // Three ADDs with req_valid held high; junk on req_* while busy
        hop = '{ADD, ADD, ADD};
        hrd = '{3'd6, 3'd7, 3'd6};
        hs1 = '{3'd1, 3'd6, 3'd7};
        hs2 = '{3'd2, 3'd1, 3'd7};
        acc_q.delete();
        start = n_acc;
        set_req(hop[0], hrd[0], hs1[0], hs2[0], 8'h00);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            got = n_acc - start;
            if (got >= 3) begin
                bus.req_valid = 1'b0;
                if (bus.req_ready === 1'b1) break;
            end else if (bus.req_ready === 1'b1) begin
                set_req(hop[got], hrd[got], hs1[got], hs2[got], 8'h00);
            end else begin
                set_req(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            end
        end
        bus.req_valid = 1'b0;
        check("held_accepts", 32'(n_acc - start), 32'd3);
        if (acc_q.size() == 3) begin
            check("held_gap0", 32'(acc_q[1] - acc_q[0]), 32'd5);
            check("held_gap1", 32'(acc_q[2] - acc_q[1]), 32'd5);
        end
        check("held_r6", 32'(bank[6]), 32'h2E);
        check("held_r7", 32'(bank[7]), 32'h17);

        // Reset during EXEC of ADD r5 = r1 + r2
        d0 = done_cnt;
        set_req(ADD, 3'd5, 3'd1, 3'd2, 8'h00);
        bus.req_valid = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("exec_alu_a", 32'(bus.alu_a), 32'h0A);
        check("exec_alu_b", 32'(bus.alu_b), 32'h03);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_alu_a", 32'(bus.alu_a),     32'd0);
        check("mid_rst_alu_op",32'(bus.alu_op),    32'd0);
        check("mid_rst_en_in", 32'(bus.rf_en_in),  32'd0);
        check("mid_rst_done",  32'(bus.done),      32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_r5",   32'(bank[5]), 32'h00);
        check("rst_done", 32'(done_cnt - d0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
